// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: word-addressed instruction memory, PC+4, IF/ID register
// with stall/flush/halt priority, sticky HALT detection and a debug load port.
module instruction_fetch #(
    parameter int                NBITS     = 32,
    parameter int                MEM_DEPTH = 256,
    parameter int                ADDR_BITS = 8,
    parameter logic [NBITS-1:0]  HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  logic [NBITS-1:0]     i_PC,
    input  logic                 i_wr_en,
    input  logic [ADDR_BITS-1:0] i_wr_addr,
    input  logic [NBITS-1:0]     i_wr_data,
    output logic [NBITS-1:0]     o_instruction,
    output logic [NBITS-1:0]     o_PC_plus4,
    output logic                 o_valid,
    output logic                 o_halt,
    output logic [NBITS-1:0]     o_fetch_count
);

    localparam logic [NBITS-1:0] ZERO_WORD = {NBITS{1'b0}};
    localparam logic [NBITS-1:0] FOUR_WORD = {{(NBITS-3){1'b0}}, 3'b100};
    localparam logic [NBITS-1:0] ONE_WORD  = {{(NBITS-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_n;
    logic [NBITS-1:0]       mem_r [MEM_DEPTH];
    logic [ADDR_BITS-1:0]   fetch_idx_s;
    logic [NBITS-1:0]       fetch_word_s;
    logic [NBITS-1:0]       pc_plus4_s;
    logic                   fetch_s;
    logic                   halt_fetch_s;
    logic [NBITS-1:0]       instr_r;
    logic [NBITS-1:0]       instr_n;
    logic [NBITS-1:0]       pc4_r;
    logic [NBITS-1:0]       pc4_n;
    logic                   valid_r;
    logic                   valid_n;
    logic [NBITS-1:0]       count_r;
    logic [NBITS-1:0]       count_n;

    // Byte offset and bits above the memory range are dropped, so the index wraps.
    assign fetch_idx_s  = i_PC[ADDR_BITS+1:2];
    assign fetch_word_s = mem_r[fetch_idx_s];
    assign pc_plus4_s   = i_PC + FOUR_WORD;

    // A real fetch happens only when nothing above it in the priority chain applies.
    assign fetch_s      = !i_wr_en && i_enable && (state_r == ST_RUN) && !i_stall && !i_flush;
    assign halt_fetch_s = fetch_s && (fetch_word_s == HALT_WORD);

    // Instruction memory write port; a write concurrent with reset is dropped.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && !i_reset) begin
            mem_r[i_wr_addr] <= i_wr_data;
        end
    end

    // IF/ID next-value selection in priority order (reset is applied in the register).
    always_comb begin
        instr_n = instr_r;
        pc4_n   = pc4_r;
        valid_n = valid_r;
        count_n = count_r;
        if (i_wr_en || !i_enable) begin
            instr_n = instr_r;
            valid_n = valid_r;
        end else if (state_r == ST_HALTED) begin
            instr_n = ZERO_WORD;
            valid_n = 1'b0;
        end else if (i_stall) begin
            instr_n = instr_r;
            valid_n = valid_r;
        end else if (i_flush) begin
            instr_n = ZERO_WORD;
            valid_n = 1'b0;
        end else begin
            instr_n = fetch_word_s;
            pc4_n   = pc_plus4_s;
            valid_n = 1'b1;
            count_n = count_r + ONE_WORD;
        end
    end

    // Run/halted control: only an accepted HALT fetch enters HALTED, only reset leaves it.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_RUN: begin
                if (halt_fetch_s) begin
                    state_n = ST_HALTED;
                end else begin
                    state_n = ST_RUN;
                end
            end
            ST_HALTED: state_n = ST_HALTED;
            default:   state_n = ST_RUN;
        endcase
    end

    // State and IF/ID pipeline registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= ST_RUN;
            instr_r <= ZERO_WORD;
            pc4_r   <= ZERO_WORD;
            valid_r <= 1'b0;
            count_r <= ZERO_WORD;
        end else begin
            state_r <= state_n;
            instr_r <= instr_n;
            pc4_r   <= pc4_n;
            valid_r <= valid_n;
            count_r <= count_n;
        end
    end

    assign o_instruction = instr_r;
    assign o_PC_plus4    = pc4_r;
    assign o_valid       = valid_r;
    assign o_halt        = (state_r == ST_HALTED);
    assign o_fetch_count = count_r;

    instruction_fetch_checker #(
        .NBITS     (NBITS),
        .HALT_WORD (HALT_WORD)
    ) u_checker (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .o_instruction (instr_r),
        .o_valid       (valid_r),
        .o_halt        (o_halt)
    );

endmodule

// Invariants of the IF/ID register and the halt flag.
module instruction_fetch_checker #(
    parameter int               NBITS     = 32,
    parameter logic [NBITS-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input logic             i_clk,
    input logic             i_reset,
    input logic [NBITS-1:0] o_instruction,
    input logic             o_valid,
    input logic             o_halt
);

    // Every bubble is encoded as an all-zero NOP.
    a_bubble_is_nop: assert property (@(posedge i_clk) !o_valid |-> (o_instruction == {NBITS{1'b0}}));

    // Halt is sticky until reset.
    a_halt_sticky: assert property (@(posedge i_clk) disable iff (i_reset) o_halt |=> o_halt);

    // Halt rises together with a valid HALT word in IF/ID.
    a_halt_with_word: assert property (@(posedge i_clk)
        $rose(o_halt) |-> (o_valid && (o_instruction == HALT_WORD)));

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: stimulus pushes expected IF/ID state into a
// queue, a negedge monitor pops and compares after every clocked step.
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        stall;
    logic        flush;
    logic [31:0] pc;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] instruction;
    logic [31:0] pc_plus4;
    logic        valid;
    logic        halt;
    logic [31:0] fetch_count;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        halt;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    instruction_fetch dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_enable      (enable),
        .i_stall       (stall),
        .i_flush       (flush),
        .i_PC          (pc),
        .i_wr_en       (wr_en),
        .i_wr_addr     (wr_addr),
        .i_wr_data     (wr_data),
        .o_instruction (instruction),
        .o_PC_plus4    (pc_plus4),
        .o_valid       (valid),
        .o_halt        (halt),
        .o_fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expectation per clocked step, compared away from the rising edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (instruction !== e.instr || pc_plus4 !== e.pc4 || valid !== e.valid ||
                halt !== e.halt || fetch_count !== e.cnt) begin
                errors++;
                $display("FAIL %s: got instr=%h pc4=%h valid=%b halt=%b cnt=%0d, want instr=%h pc4=%h valid=%b halt=%b cnt=%0d",
                         e.name, instruction, pc_plus4, valid, halt, fetch_count,
                         e.instr, e.pc4, e.valid, e.halt, e.cnt);
            end
        end
    end

    task automatic step(input string name, input logic rst, input logic en, input logic stl,
                        input logic fls, input logic [31:0] p, input logic we,
                        input logic [7:0] wa, input logic [31:0] wd,
                        input logic [31:0] x_instr, input logic [31:0] x_pc4,
                        input logic x_valid, input logic x_halt, input logic [31:0] x_cnt);
        exp_t e;
        reset   = rst;
        enable  = en;
        stall   = stl;
        flush   = fls;
        pc      = p;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        e.name  = name;
        e.instr = x_instr;
        e.pc4   = x_pc4;
        e.valid = x_valid;
        e.halt  = x_halt;
        e.cnt   = x_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic fetch(input string name, input logic [31:0] p,
                         input logic [31:0] x_instr, input logic [31:0] x_pc4,
                         input logic x_valid, input logic x_halt, input logic [31:0] x_cnt);
        step(name, 1'b0, 1'b1, 1'b0, 1'b0, p, 1'b0, 8'd0, 32'd0,
             x_instr, x_pc4, x_valid, x_halt, x_cnt);
    endtask

    task automatic load(input string name, input logic [7:0] a, input logic [31:0] d,
                        input logic [31:0] x_instr, input logic [31:0] x_pc4,
                        input logic x_valid, input logic x_halt, input logic [31:0] x_cnt);
        step(name, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, a, d,
             x_instr, x_pc4, x_valid, x_halt, x_cnt);
    endtask

    initial begin
        step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'd0,
             32'd0, 32'd0, 1'b0, 1'b0, 32'd0);

        // Program load; IF/ID stays at reset values throughout.
        load("load0",   8'd0,   32'h2001_0005, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        load("load1",   8'd1,   32'h2002_0007, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        load("load2",   8'd2,   32'h0000_0000, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        load("load3",   8'd3,   32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        load("load5",   8'd5,   32'h1234_5678, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        load("load6",   8'd6,   32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        load("load255", 8'd255, 32'h0BAD_F00D, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);

        // Load and run up to HALT, then drain.
        fetch("run_pc0",  32'd0,  32'h2001_0005, 32'd4,  1'b1, 1'b0, 32'd1);
        fetch("run_pc4",  32'd4,  32'h2002_0007, 32'd8,  1'b1, 1'b0, 32'd2);
        fetch("run_pc8",  32'd8,  32'h0000_0000, 32'd12, 1'b1, 1'b0, 32'd3);
        fetch("halt_rise", 32'd12, 32'hFFFF_FFFF, 32'd16, 1'b1, 1'b1, 32'd4);
        fetch("drain1",   32'd16, 32'd0, 32'd16, 1'b0, 1'b1, 32'd4);
        fetch("drain2",   32'd16, 32'd0, 32'd16, 1'b0, 1'b1, 32'd4);

        // Reset mid-halt, memory preserved.
        step("reset_halt", 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'd0,
             32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        fetch("refetch0", 32'd0, 32'h2001_0005, 32'd4, 1'b1, 1'b0, 32'd1);

        // Stall outranks flush, then flush alone.
        fetch("pre_stall", 32'd4, 32'h2002_0007, 32'd8, 1'b1, 1'b0, 32'd2);
        step("stall_flush", 1'b0, 1'b1, 1'b1, 1'b1, 32'd8, 1'b0, 8'd0, 32'd0,
             32'h2002_0007, 32'd8, 1'b1, 1'b0, 32'd2);
        step("flush_only", 1'b0, 1'b1, 1'b0, 1'b1, 32'd8, 1'b0, 8'd0, 32'd0,
             32'd0, 32'd8, 1'b0, 1'b0, 32'd2);
        fetch("after_flush", 32'd8, 32'h0000_0000, 32'd12, 1'b1, 1'b0, 32'd3);

        // Wrap and alignment.
        fetch("wrap_403", 32'h0000_0403, 32'h2001_0005, 32'h0000_0407, 1'b1, 1'b0, 32'd4);
        fetch("pc_top",   32'hFFFF_FFFC, 32'h0BAD_F00D, 32'h0000_0000, 1'b1, 1'b0, 32'd5);

        // Write suspends fetch, new word visible afterwards.
        step("wr_collide", 1'b0, 1'b1, 1'b0, 1'b0, 32'd8, 1'b1, 8'd2, 32'h2003_0009,
             32'h0BAD_F00D, 32'd0, 1'b1, 1'b0, 32'd5);
        fetch("after_wr", 32'd8, 32'h2003_0009, 32'd12, 1'b1, 1'b0, 32'd6);

        // Disabled: nothing moves, even with flush or a HALT address.
        step("dis1", 1'b0, 1'b0, 1'b0, 1'b1, 32'd4, 1'b0, 8'd0, 32'd0,
             32'h2003_0009, 32'd12, 1'b1, 1'b0, 32'd6);
        step("dis2", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'd0,
             32'h2003_0009, 32'd12, 1'b1, 1'b0, 32'd6);
        step("dis3", 1'b0, 1'b0, 1'b0, 1'b0, 32'd12, 1'b0, 8'd0, 32'd0,
             32'h2003_0009, 32'd12, 1'b1, 1'b0, 32'd6);

        // Flushed and stalled HALT words do not halt; an accepted one does.
        step("halt_flushed", 1'b0, 1'b1, 1'b0, 1'b1, 32'd24, 1'b0, 8'd0, 32'd0,
             32'd0, 32'd12, 1'b0, 1'b0, 32'd6);
        step("halt_stalled", 1'b0, 1'b1, 1'b1, 1'b0, 32'd24, 1'b0, 8'd0, 32'd0,
             32'd0, 32'd12, 1'b0, 1'b0, 32'd6);
        fetch("halt_taken", 32'd24, 32'hFFFF_FFFF, 32'd28, 1'b1, 1'b1, 32'd7);
        fetch("halted_nop", 32'd20, 32'd0, 32'd28, 1'b0, 1'b1, 32'd7);
        step("halted_stall", 1'b0, 1'b1, 1'b1, 1'b0, 32'd20, 1'b0, 8'd0, 32'd0,
             32'd0, 32'd28, 1'b0, 1'b1, 32'd7);

        // Reset with a concurrent write: the write is dropped.
        step("reset_wr", 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 8'd0, 32'hDEAD_BEEF,
             32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        fetch("wr_dropped", 32'd0,  32'h2001_0005, 32'd4,  1'b1, 1'b0, 32'd1);
        fetch("fetch_mem5", 32'd20, 32'h1234_5678, 32'd24, 1'b1, 1'b0, 32'd2);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage of the 5-stage MIPS pipeline, directly downstream of the program counter register. Takes the registered PC, reads a word-addressed instruction memory, computes PC+4, and latches instruction and PC+4 into the IF/ID pipeline register under stall/flush control. Also detects the HALT word and drives the sticky halt flag back to the program counter, and exposes a load port that the debug unit uses to write the program before execution.

## Interface

Parameters:
- NBITS, 32, datapath, instruction and PC width
- MEM_DEPTH, 256, instruction memory depth in words
- ADDR_BITS, 8, word-address width, equal to log2(MEM_DEPTH)
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch

Ports:
- i_clk  in  1  single clock; all state updates on its rising edge
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  global run/step enable from the debug unit; low freezes all fetch state
- i_stall  in  1  load-use hazard stall; holds IF/ID
- i_flush  in  1  branch/jump taken in ID; inserts a bubble into IF/ID
- i_PC  in  NBITS  current PC, byte address, from the program counter output
- i_wr_en  in  1  instruction memory write strobe from the debug unit
- i_wr_addr  in  ADDR_BITS  word address for the write
- i_wr_data  in  NBITS  instruction word to write
- o_instruction  out  NBITS  IF/ID instruction
- o_PC_plus4  out  NBITS  IF/ID PC+4
- o_valid  out  1  IF/ID holds a real fetched instruction, not a bubble
- o_halt  out  1  sticky halt, fed to the program counter's halt input
- o_fetch_count  out  NBITS  number of valid instructions latched into IF/ID

## Operation

- Fetch word index is i_PC[ADDR_BITS+1:2]. i_PC[1:0] is ignored. Bits above ADDR_BITS+1 are also ignored, so the index wraps modulo MEM_DEPTH.
- Memory read is combinational (asynchronous). The memory write is clocked.
  - A write and a read of the same index in the same cycle returns the old word (read-before-write).
- Memory contents are not cleared by reset.
- PC+4 uses NBITS-bit unsigned addition and wraps: 32'hFFFF_FFFC gives 32'h0000_0000.
- IF/ID update priority, evaluated each rising edge:
  1. i_reset: o_instruction=0, o_PC_plus4=0, o_valid=0, o_halt=0, o_fetch_count=0.
  2. i_wr_en: memory is written. IF/ID and o_halt hold. Fetch is suspended even if i_enable=1.
  3. !i_enable: everything holds.
  4. o_halt=1: IF/ID loads instruction 0 (NOP), PC+4 holds, o_valid=0. This drains the pipeline.
  5. i_stall: IF/ID holds. Stall outranks flush, because the branch in ID is itself stalled.
  6. i_flush: o_instruction=0, o_valid=0, o_PC_plus4 holds.
  7. Otherwise: o_instruction=mem[index], o_PC_plus4=i_PC+4, o_valid=1, o_fetch_count increments (wrapping).
- Halt detection, only in case 7:
  - If mem[index]==HALT_WORD, the word is latched with o_valid=1 and o_halt sets on the same edge.
  - o_halt stays high until i_reset.
  - A HALT word that is flushed or stalled does not set o_halt.
- Two-state control: RUN (o_halt=0) and HALTED (o_halt=1).
  - RUN to HALTED on a HALT fetch.
  - HALTED to RUN only on i_reset.

## Timing

- Latency: one cycle from i_PC to the IF/ID outputs.
- o_halt is registered and asserts in the same cycle the HALT word appears on o_instruction. The PC therefore freezes one cycle later, holding HALT's address+4.
- i_stall and i_flush are sampled on the edge, with no registering inside the block.
- Reset mid-fetch, or during a write, takes effect on that edge and overrides everything. A write that is concurrent with reset is dropped.
- Reset values: o_instruction=0, o_PC_plus4=0, o_valid=0, o_halt=0, o_fetch_count=0.

## Test plan

- Load and run:
  - Stimulus: write mem[0..3]=32'h2001_0005, 32'h2002_0007, 32'h0000_0000, 32'hFFFF_FFFF, then step i_PC through 0, 4, 8, 12.
  - Expected: o_instruction follows mem one cycle later, o_PC_plus4 reads 4, 8, 12, 16, o_fetch_count=4.
  - Expected: o_halt rises with HALT, and the following enabled cycles give o_valid=0 with o_instruction=0.
- Stall vs flush:
  - Stimulus: i_PC=8 with i_stall=1 and i_flush=1 together.
  - Expected: IF/ID unchanged and o_fetch_count unchanged.
  - Stimulus: next cycle, i_flush=1 only.
  - Expected: o_instruction=0, o_valid=0, o_PC_plus4 unchanged.
- Flushed HALT:
  - Stimulus: i_PC points at a HALT word while i_flush=1.
  - Expected: o_halt stays 0.
  - Stimulus: a later unflushed fetch of the same word.
  - Expected: o_halt=1.
- Wrap and alignment:
  - Stimulus: i_PC=32'h0000_0403 with MEM_DEPTH=256.
  - Expected: fetches mem[0]. o_PC_plus4=32'h0000_0407.
  - Stimulus: i_PC=32'hFFFF_FFFC.
  - Expected: o_PC_plus4=0.
- Write collision and enable:
  - Stimulus: i_wr_en=1 writing index 2 while i_PC=8.
  - Expected: IF/ID holds, and the memory gets the new word.
  - Stimulus: i_enable=0 for 3 cycles.
  - Expected: all outputs constant.
- Reset mid-halt:
  - Stimulus: with o_halt=1, assert i_reset for 1 cycle.
  - Expected: all outputs 0 on the next edge, memory contents preserved, and a refetch from PC=0 returns the original mem[0].
